// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared PC-select and FSM encodings for the fetch controller
package fetch_ctrl_pkg;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JALR   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } fetch_state_t;

  // A redirect may only land when no response can still arrive for the old path.
  function automatic logic slot_free(input fetch_state_t state, input logic rvalid);
    return (state == ST_IDLE) || (state == ST_HOLD) || ((state == ST_WAIT) && rvalid);
  endfunction

endpackage

// File: rtl/fetch_redirect_reg.sv
// rtl/fetch_redirect_reg.sv - pending redirect register with branch-over-jalr priority and bypass
module fetch_redirect_reg
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jalr_taken_i,
  input  logic [31:0] jalr_target_i,
  input  logic        clear_i,
  output logic [31:0] pend_target_o,
  output logic        eff_valid_o,
  output logic [1:0]  eff_sel_o,
  output logic [31:0] eff_target_o
);

  logic        r_valid;
  logic [1:0]  r_sel;
  logic [31:0] r_target;
  logic        w_event;

  assign w_event = branch_taken_i | jalr_taken_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_sel    <= PC_SEL_PLUS4;
      r_target <= 32'h0;
    end else if (clear_i) begin
      r_valid  <= 1'b0;
      r_sel    <= PC_SEL_PLUS4;
      r_target <= 32'h0;
    end else if (branch_taken_i) begin
      r_valid  <= 1'b1;
      r_sel    <= PC_SEL_BRANCH;
      r_target <= branch_target_i;
    end else if (jalr_taken_i) begin
      r_valid  <= 1'b1;
      r_sel    <= PC_SEL_JALR;
      r_target <= jalr_target_i;
    end
  end

  // Same-cycle events take precedence over the stored one so they can be applied at once.
  always_comb begin
    eff_valid_o  = w_event | r_valid;
    eff_sel_o    = r_sel;
    eff_target_o = r_target;
    if (branch_taken_i) begin
      eff_sel_o    = PC_SEL_BRANCH;
      eff_target_o = branch_target_i;
    end else if (jalr_taken_i) begin
      eff_sel_o    = PC_SEL_JALR;
      eff_target_o = jalr_target_i;
    end
  end

  assign pend_target_o = r_target;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller: imem handshake, IF/ID hold buffer, redirects
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        hold_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jalr_taken_i,
  input  logic [31:0] jalr_target_i,
  output logic        stall_if_o,
  output logic        flush_if_o,
  output logic [1:0]  pc_sel_o,
  output logic [31:0] redirect_target_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_o
);

  fetch_state_t r_state;
  fetch_state_t w_next;
  logic [31:0]  r_buf;
  logic [31:0]  w_pend_target;
  logic         w_eff_valid;
  logic [1:0]   w_eff_sel;
  logic [31:0]  w_eff_target;
  logic         w_apply;
  logic         w_capture;

  // RESET_PC belongs to the downstream PC register; it must be word aligned.
  if (RESET_PC[1:0] != 2'b00) begin : g_unaligned_reset_pc
  end

  assign w_apply   = w_eff_valid & slot_free(r_state, imem_rvalid_i);
  assign w_capture = (r_state == ST_WAIT) & imem_rvalid_i & hold_i & ~w_apply;

  fetch_redirect_reg u_redirect (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jalr_taken_i    (jalr_taken_i),
    .jalr_target_i   (jalr_target_i),
    .clear_i         (w_apply),
    .pend_target_o   (w_pend_target),
    .eff_valid_o     (w_eff_valid),
    .eff_sel_o       (w_eff_sel),
    .eff_target_o    (w_eff_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = ST_FETCH;
      ST_FETCH: if (imem_gnt_i) w_next = ST_WAIT;
      ST_WAIT:  if (imem_rvalid_i) w_next = hold_i ? ST_HOLD : ST_FETCH;
      ST_HOLD:  if (!hold_i) w_next = ST_FETCH;
      default:  w_next = ST_IDLE;
    endcase
    if (w_apply) w_next = ST_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= 32'h0;
    end else if (w_apply) begin
      r_buf <= 32'h0;
    end else if (w_capture) begin
      r_buf <= imem_rdata_i;
    end
  end

  // Outputs are forced to their idle values while reset is low, even against live redirect inputs.
  always_comb begin
    imem_req_o        = 1'b0;
    stall_if_o        = 1'b1;
    flush_if_o        = 1'b0;
    pc_sel_o          = PC_SEL_PLUS4;
    redirect_target_o = w_pend_target;
    instr_valid_o     = 1'b0;
    instr_o           = 32'h0;
    if (!rst_n) begin
      redirect_target_o = 32'h0;
    end else begin
      imem_req_o = (r_state == ST_FETCH);
      if (w_apply) begin
        stall_if_o        = 1'b0;
        flush_if_o        = 1'b1;
        pc_sel_o          = w_eff_sel;
        redirect_target_o = w_eff_target;
      end else if ((r_state == ST_WAIT) && imem_rvalid_i && !hold_i) begin
        instr_valid_o = 1'b1;
        instr_o       = imem_rdata_i;
        stall_if_o    = 1'b0;
      end else if (r_state == ST_HOLD) begin
        instr_valid_o = 1'b1;
        instr_o       = r_buf;
        stall_if_o    = hold_i;
      end
    end
  end

endmodule
